usr_shift_engine: RTL and testbench

//  Parametrised universal shift register with a multi-step sequencer. Successor to the per-bit
//  4-way selector USR cell: adds rotate, arithmetic shift and clear modes, and a start/busy/done

---
 rtl/usr_pkg.sv | 34 +++
 rtl/usr_next_state.sv | 36 +++
 rtl/usr_shift_engine.sv | 114 +++++++++++
 tb/tb_usr_shift_engine.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : usr_pkg
// Brief   : Mode codes, FSM state encoding and amount clamp for the USR engine.
// Revision: 1.0
//------------------------------------------------------------------------------
package usr_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int unsigned clamp_amount(input int unsigned amt,
                                                 input int unsigned width);
        return (amt > width) ? width : amt;
    endfunction

    function automatic logic is_shift_mode(input logic [2:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL) || (m == MODE_ROR) ||
               (m == MODE_ROL) || (m == MODE_ASR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/usr_next_state.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : usr_next_state
// Brief   : One-step next value of the shift register for a given mode.
// Revision: 1.0
//------------------------------------------------------------------------------
module usr_next_state
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic [2:0]       i_mode,
    input  logic             i_ser_in_msb,
    input  logic             i_ser_in_lsb,
    input  logic [WIDTH-1:0] i_par_in,
    output logic [WIDTH-1:0] o_next
);

    always_comb begin
        o_next = i_q;
        case (i_mode)
            MODE_HOLD: o_next = i_q;
            MODE_SHR:  o_next = {i_ser_in_msb, i_q[WIDTH-1:1]};
            MODE_SHL:  o_next = {i_q[WIDTH-2:0], i_ser_in_lsb};
            MODE_LOAD: o_next = i_par_in;
            MODE_ROR:  o_next = {i_q[0], i_q[WIDTH-1:1]};
            MODE_ROL:  o_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
            MODE_ASR:  o_next = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
            MODE_CLR:  o_next = '0;
            default:   o_next = i_q;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/usr_shift_engine.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : usr_shift_engine
// Brief   : Universal shift register with start/busy/done multi-step sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
module usr_shift_engine
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amount,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             ser_out_msb,
    output logic             ser_out_lsb
);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [2:0]       r_mode,  w_mode_nxt;
    logic [WIDTH-1:0] r_q,     w_q_nxt;
    logic             r_done,  w_done_nxt;
    logic [CNT_W-1:0] w_amt_eff;
    logic [2:0]       w_step_mode;
    logic [WIDTH-1:0] w_step;

    assign w_amt_eff   = CNT_W'(clamp_amount(32'(amount), WIDTH));
    // While idle the step is previewed with the incoming mode; while shifting, the latched one.
    assign w_step_mode = (r_state == ST_IDLE) ? mode : r_mode;

    usr_next_state #(.WIDTH(WIDTH)) u_next (
        .i_q          (r_q),
        .i_mode       (w_step_mode),
        .i_ser_in_msb (ser_in_msb),
        .i_ser_in_lsb (ser_in_lsb),
        .i_par_in     (par_in),
        .o_next       (w_step)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_mode_nxt  = r_mode;
        w_q_nxt     = r_q;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_mode_nxt  = mode;
                    w_count_nxt = '0;
                    if (!is_shift_mode(mode)) begin
                        w_q_nxt    = w_step;
                        w_done_nxt = 1'b1;
                    end else if (w_amt_eff == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_q_nxt = w_step;
                        if (w_amt_eff == CNT_W'(1)) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_SHIFT;
                            w_count_nxt = w_amt_eff - CNT_W'(1);
                        end
                    end
                end
            end
            ST_SHIFT: begin
                w_q_nxt = w_step;
                if (r_count == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_count_nxt = r_count - CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_mode  <= MODE_HOLD;
            r_q     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_mode  <= w_mode_nxt;
            r_q     <= w_q_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign q           = r_q;
    assign busy        = (r_state == ST_SHIFT);
    assign done        = r_done;
    assign ser_out_msb = r_q[WIDTH-1];
    assign ser_out_lsb = r_q[0];

endmodule
`default_nettype wire

// File: tb/tb_usr_shift_engine.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_usr_shift_engine
// Brief   : Directed self-checking bench for usr_shift_engine (WIDTH=8).
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_usr_shift_engine;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] amount;
    logic             ser_in_msb;
    logic             ser_in_lsb;
    logic [WIDTH-1:0] par_in;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             ser_out_msb;
    logic             ser_out_lsb;

    int n_cmp = 0;
    int n_err = 0;

    usr_shift_engine #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .mode        (mode),
        .amount      (amount),
        .ser_in_msb  (ser_in_msb),
        .ser_in_lsb  (ser_in_lsb),
        .par_in      (par_in),
        .q           (q),
        .busy        (busy),
        .done        (done),
        .ser_out_msb (ser_out_msb),
        .ser_out_lsb (ser_out_lsb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [7:0] eq, input logic eb,
                          input logic ed);
        chk({tag, ".q"},    32'(q),    32'(eq));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".done"}, 32'(done), 32'(ed));
    endtask

    task automatic go(input logic [2:0] m, input logic [3:0] a, input logic [7:0] p);
        start  = 1'b1;
        mode   = m;
        amount = a;
        par_in = p;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 3'b000; amount = '0;
        ser_in_msb = 1'b0; ser_in_lsb = 1'b0; par_in = '0;
        repeat (2) tick();
        chk_st("reset", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        // LOAD, then HOLD
        go(3'b011, 4'd0, 8'hB4);
        tick(); start = 1'b0;
        chk_st("load", 8'hB4, 1'b0, 1'b1);
        chk("load.sermsb", 32'(ser_out_msb), 32'd1);
        chk("load.serlsb", 32'(ser_out_lsb), 32'd0);
        tick();
        chk("load.done_clear", 32'(done), 32'd0);
        go(3'b000, 4'd0, 8'h00);
        tick(); start = 1'b0;
        chk_st("hold", 8'hB4, 1'b0, 1'b1);

        // SHR by 3 with ser_in_msb=1
        ser_in_msb = 1'b1;
        go(3'b001, 4'd3, 8'h00);
        tick(); start = 1'b0;
        chk_st("shr.s1", 8'hDA, 1'b1, 1'b0);
        tick();
        chk_st("shr.s2", 8'hED, 1'b1, 1'b0);
        tick();
        chk_st("shr.s3", 8'hF6, 1'b0, 1'b1);
        tick();
        chk_st("shr.after", 8'hF6, 1'b0, 1'b0);

        // ROL by 12 clamps to 8 and returns the original value
        go(3'b011, 4'd0, 8'h81);
        tick();
        go(3'b101, 4'd12, 8'h00);
        tick(); start = 1'b0;
        chk_st("rol.s1", 8'h03, 1'b1, 1'b0);
        repeat (6) tick();
        chk_st("rol.s7", 8'hC0, 1'b1, 1'b0);
        tick();
        chk_st("rol.s8", 8'h81, 1'b0, 1'b1);

        // ASR by 2; CLR start while busy is ignored; LOAD in the done cycle is taken
        go(3'b011, 4'd0, 8'h90);
        tick();
        go(3'b110, 4'd2, 8'h00);
        tick();
        chk_st("asr.s1", 8'hC8, 1'b1, 1'b0);
        go(3'b111, 4'd0, 8'h00);
        tick();
        chk_st("asr.s2", 8'hE4, 1'b0, 1'b1);
        go(3'b011, 4'd0, 8'h0F);
        tick(); start = 1'b0;
        chk_st("b2b.load", 8'h0F, 1'b0, 1'b1);

        // SHL amount 0 leaves q; amount 1 completes in one edge
        ser_in_lsb = 1'b1;
        go(3'b010, 4'd0, 8'h00);
        tick(); start = 1'b0;
        chk_st("shl0", 8'h0F, 1'b0, 1'b1);
        go(3'b010, 4'd1, 8'h00);
        tick(); start = 1'b0;
        chk_st("shl1", 8'h1F, 1'b0, 1'b1);

        // ROR by 2 then CLR
        go(3'b100, 4'd2, 8'h00);
        tick(); start = 1'b0;
        tick();
        chk_st("ror2", 8'hC7, 1'b0, 1'b1);
        go(3'b111, 4'd0, 8'h00);
        tick(); start = 1'b0;
        chk_st("clr", 8'h00, 1'b0, 1'b1);

        // Async reset in mid-shift abandons the operation without a done
        go(3'b011, 4'd0, 8'hA5);
        tick();
        ser_in_msb = 1'b0;
        go(3'b001, 4'd5, 8'h00);
        tick(); start = 1'b0;
        chk_st("rst.pre", 8'h52, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_st("rst.async", 8'h00, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            chk_st("rst.nodone", 8'h00, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
